control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle control FSM for the 16-bit processor. It consumes `Ir` and `Flags` from `datapath` and generates every `datapath` control strobe: bus enables, register write enables and mux selects. It also runs the external memory handshake (address latch, read/write strobes, `MemReady` wait states). Together with `datapath` it forms the processor core.

## Interface
Parameters: none.

- `Clock`  in  1  single system clock; all state changes on the rising edge.
- `nReset`  in  1  synchronous, active-low reset; one clock, sampled on the rising edge.
- `Ir`  in  16  current instruction from `datapath`.
- `Flags`  in  4  `{Z,N,C,V}` as bits 3..0, from `datapath`.
- `MemReady`  in  1  memory completes the current read/write this cycle.
- `AluEn, MemEn, PcEn, LrEn`  out  1 each  SysBus drivers: ALU out, `DataIn`, Pc, Lr. At most one is high per cycle.
- `AluWe`  out  1  update `Flags`.
- `IrWe`  out  1  Ir <- SysBus.
- `PcWe`  out  1  write Pc.
- `PcSel`  out  2  Pc source: 00 = Pc+1, 01 = AluOut, 10 = Lr.
- `LrWe`  out  1  write Lr.
- `LrSel`  out  1  Lr source: 0 = Pc, 1 = SysBus.
- `RegWe`  out  1  write the register file.
- `WdSel`  out  1  write data source: 0 = AluOut, 1 = SysBus.
- `RwSel`  out  2  write register: 00 = Ir[10:8].
- `Rs1Sel`  out  2  Op1 register: 00 = Ir[7:5], 01 = Ir[10:8].
- `Op1Sel`  out  1  0 = register, 1 = Pc.
- `Op2Sel`  out  1  0 = register Ir[4:2], 1 = immediate.
- `ImmSel`  out  1  0 = sign-extended Ir[4:0], 1 = sign-extended Ir[7:0].
- `CFlag`  out  1  carry-in to the ALU; equals `Flags[1]`.
- `MemAle`  out  1  memory latches SysBus as the address.
- `MemRead`  out  1  memory read strobe.
- `MemWrite`  out  1  memory write strobe.
- `Halted`  out  1  high in state HALT.

## Operation
- States: FETCH, LOADIR, EXEC, MEM, HALT. State is encoded in a register. Outputs decode combinationally from state, `Ir`, `Flags` and `MemReady`.
- Opcode is `Ir[15:12]`:
  - 0000–0111: ALU. `Ir[11]=1` selects the immediate form.
  - 1000: LDW.
  - 1001: STW.
  - 1010: BR.
  - 1011: BL.
  - 1100: RET.
  - 1101, 1110: NOP.
  - 1111: HALT.
- FETCH: PcEn, MemAle, PcWe, PcSel=00. Next state: LOADIR.
- LOADIR: MemEn, MemRead. If MemReady=0, stay in LOADIR. If MemReady=1, assert IrWe and go to EXEC.
- EXEC, by opcode; all go to FETCH unless stated:
  - ALU: Rs1Sel=00, Op1Sel=0, Op2Sel=`Ir[11]`, ImmSel=0, AluEn, AluWe, WdSel=0, RwSel=00, RegWe.
  - LDW/STW: Rs1Sel=00, Op2Sel=1, ImmSel=0, AluEn, MemAle. Next state: MEM. No AluWe.
  - BR: decode condition `Ir[11:8]`:
    - 0 always; 1 Z; 2 !Z; 3 C; 4 !C; 5 N; 6 !N; 7 V; 8 !V.
    - 9 N!=V; 10 N==V; 11–15 never.
    - If true: Op1Sel=1, Op2Sel=1, ImmSel=1, AluEn, PcSel=01, PcWe. Target = incremented Pc + simm8.
  - BL: LrWe with LrSel=0, plus the taken-branch signals, unconditionally.
  - RET: PcSel=10, PcWe.
  - NOP: no strobes.
  - HALT: go to HALT.
- MEM, LDW: MemEn, MemRead, WdSel=1, RwSel=00. RegWe only in the cycle MemReady=1, then FETCH.
- MEM, STW: Rs1Sel=01, Op1Sel=0, AluEn (datapath forces ALU pass-Op1 for opcode 1001), MemWrite. Hold until MemReady=1, then FETCH.
- HALT: all strobes 0, Halted=1. Only reset leaves HALT.
- `MemReady` is ignored outside LOADIR and MEM.

## Timing
- Reset: any rising edge with nReset=0 sets state to FETCH. While nReset=0, every output is forced to 0 combinationally, including Halted. CFlag is the exception and follows `Flags[1]`.
- First cycle after reset release is FETCH.
- Latency with zero wait states:
  - ALU, BR, BL, RET, NOP: 3 cycles.
  - LDW, STW: 4 cycles.
  - Each cycle with MemReady=0 in LOADIR or MEM adds exactly 1 cycle.
- Reset mid-operation (e.g. in MEM during a wait): strobes drop in the same cycle; the next state is FETCH; the pending load writes nothing.
- Flags for a BR are those present during EXEC, i.e. the result of the last AluWe.
- Bus exclusivity: no cycle asserts more than one of AluEn, MemEn, PcEn, LrEn.

## Test plan
- Reset release, MemReady=1, memory returns ALU op 0x0123: FETCH/LOADIR/EXEC. IrWe in cycle 2; RegWe and AluWe in cycle 3; FETCH again in cycle 4.
- LDW 0x8000 with MemReady low for 2 MEM cycles: RegWe asserted only in the 3rd MEM cycle; total 6 cycles.
- BR with cond 1: Flags=4'b1000 → PcWe with PcSel=01. Flags=4'b0000 → no PcWe, 3 cycles.
- BL then RET: BL EXEC asserts LrWe=1, LrSel=0, PcSel=01. RET EXEC asserts PcSel=10, PcWe.
- HALT 0xF000: Halted=1 and no strobes for 10 cycles. nReset=0 for one edge → FETCH, Halted=0.
- nReset=0 during STW MEM wait: MemWrite drops the same cycle; FETCH follows release; bus-exclusivity assertion holds throughout.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the 16-bit core: sequences fetch, execute and
// memory phases and drives every datapath strobe plus the memory handshake.
module control_unit (
   input  logic        Clock,
   input  logic        nReset,
   input  logic [15:0] Ir,
   input  logic [3:0]  Flags,
   input  logic        MemReady,
   output logic        AluEn,
   output logic        MemEn,
   output logic        PcEn,
   output logic        LrEn,
   output logic        AluWe,
   output logic        IrWe,
   output logic        PcWe,
   output logic [1:0]  PcSel,
   output logic        LrWe,
   output logic        LrSel,
   output logic        RegWe,
   output logic        WdSel,
   output logic [1:0]  RwSel,
   output logic [1:0]  Rs1Sel,
   output logic        Op1Sel,
   output logic        Op2Sel,
   output logic        ImmSel,
   output logic        CFlag,
   output logic        MemAle,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        Halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_LOADIR = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_HALT   = 3'd4
   } state_e;

   state_e state_q;
   state_e state_d;

   logic [3:0] op;
   logic       is_alu;
   logic       is_ldw;
   logic       is_stw;
   logic       is_mem;
   logic       is_br;
   logic       is_bl;
   logic       is_ret;
   logic       is_halt;
   logic       br_take;
   logic       fz, fn, fc, fv;
   logic       unused_ir;

   assign op      = Ir[15:12];
   assign is_alu  = ~op[3];
   assign is_ldw  = (op == 4'b1000);
   assign is_stw  = (op == 4'b1001);
   assign is_mem  = is_ldw | is_stw;
   assign is_br   = (op == 4'b1010);
   assign is_bl   = (op == 4'b1011);
   assign is_ret  = (op == 4'b1100);
   assign is_halt = (op == 4'b1111);

   assign fz = Flags[3];
   assign fn = Flags[2];
   assign fc = Flags[1];
   assign fv = Flags[0];

   // Offset/immediate bits are consumed by the datapath, not here.
   assign unused_ir = ^Ir[7:0];

   assign CFlag = Flags[1];

   always_comb begin
      br_take = 1'b0;
      unique case (Ir[11:8])
         4'd0:    br_take = 1'b1;
         4'd1:    br_take = fz;
         4'd2:    br_take = ~fz;
         4'd3:    br_take = fc;
         4'd4:    br_take = ~fc;
         4'd5:    br_take = fn;
         4'd6:    br_take = ~fn;
         4'd7:    br_take = fv;
         4'd8:    br_take = ~fv;
         4'd9:    br_take = fn ^ fv;
         4'd10:   br_take = ~(fn ^ fv);
         default: br_take = 1'b0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (!nReset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:  state_d = S_LOADIR;
         S_LOADIR: state_d = MemReady ? S_EXEC : S_LOADIR;
         S_EXEC: begin
            if (is_mem) begin
               state_d = S_MEM;
            end else if (is_halt) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_MEM:    state_d = MemReady ? S_FETCH : S_MEM;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_FETCH;
      endcase
   end

   // All strobes are held low while reset is asserted, whatever the state.
   always_comb begin
      AluEn    = 1'b0;
      MemEn    = 1'b0;
      PcEn     = 1'b0;
      LrEn     = 1'b0;
      AluWe    = 1'b0;
      IrWe     = 1'b0;
      PcWe     = 1'b0;
      PcSel    = 2'b00;
      LrWe     = 1'b0;
      LrSel    = 1'b0;
      RegWe    = 1'b0;
      WdSel    = 1'b0;
      RwSel    = 2'b00;
      Rs1Sel   = 2'b00;
      Op1Sel   = 1'b0;
      Op2Sel   = 1'b0;
      ImmSel   = 1'b0;
      MemAle   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      Halted   = 1'b0;
      if (nReset) begin
         unique case (state_q)
            S_FETCH: begin
               PcEn   = 1'b1;
               MemAle = 1'b1;
               PcWe   = 1'b1;
            end
            S_LOADIR: begin
               MemEn   = 1'b1;
               MemRead = 1'b1;
               IrWe    = MemReady;
            end
            S_EXEC: begin
               unique case (1'b1)
                  is_alu: begin
                     AluEn  = 1'b1;
                     AluWe  = 1'b1;
                     RegWe  = 1'b1;
                     Op2Sel = Ir[11];
                  end
                  is_mem: begin
                     AluEn  = 1'b1;
                     Op2Sel = 1'b1;
                     MemAle = 1'b1;
                  end
                  is_bl, (is_br & br_take): begin
                     Op1Sel = 1'b1;
                     Op2Sel = 1'b1;
                     ImmSel = 1'b1;
                     AluEn  = 1'b1;
                     PcSel  = 2'b01;
                     PcWe   = 1'b1;
                     LrWe   = is_bl;
                  end
                  is_ret: begin
                     PcSel = 2'b10;
                     PcWe  = 1'b1;
                  end
                  default: ;
               endcase
            end
            S_MEM: begin
               if (is_ldw) begin
                  MemEn   = 1'b1;
                  MemRead = 1'b1;
                  WdSel   = 1'b1;
                  RegWe   = MemReady;
               end else begin
                  Rs1Sel   = 2'b01;
                  AluEn    = 1'b1;
                  MemWrite = 1'b1;
               end
            end
            S_HALT:  Halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction vector table plus
// hand-written wait-state, halt and mid-operation reset sequences.
module tb_control_unit;

   logic        Clock;
   logic        nReset;
   logic [15:0] Ir;
   logic [3:0]  Flags;
   logic        MemReady;
   logic        AluEn, MemEn, PcEn, LrEn, AluWe, IrWe, PcWe;
   logic [1:0]  PcSel;
   logic        LrWe, LrSel, RegWe, WdSel;
   logic [1:0]  RwSel, Rs1Sel;
   logic        Op1Sel, Op2Sel, ImmSel, CFlag;
   logic        MemAle, MemRead, MemWrite, Halted;

   int passed = 0;
   int total  = 0;
   bit started = 0;

   control_unit dut (
      .Clock(Clock), .nReset(nReset), .Ir(Ir), .Flags(Flags),
      .MemReady(MemReady),
      .AluEn(AluEn), .MemEn(MemEn), .PcEn(PcEn), .LrEn(LrEn),
      .AluWe(AluWe), .IrWe(IrWe), .PcWe(PcWe), .PcSel(PcSel),
      .LrWe(LrWe), .LrSel(LrSel), .RegWe(RegWe), .WdSel(WdSel),
      .RwSel(RwSel), .Rs1Sel(Rs1Sel), .Op1Sel(Op1Sel),
      .Op2Sel(Op2Sel), .ImmSel(ImmSel), .CFlag(CFlag),
      .MemAle(MemAle), .MemRead(MemRead), .MemWrite(MemWrite),
      .Halted(Halted)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic [24:0] outv;
   assign outv = {AluEn, MemEn, PcEn, LrEn, AluWe, IrWe, PcWe, PcSel,
                  LrWe, LrSel, RegWe, WdSel, RwSel, Rs1Sel, Op1Sel,
                  Op2Sel, ImmSel, CFlag, MemAle, MemRead, MemWrite,
                  Halted};

   localparam logic [24:0] M_ALUEN    = 25'd1 << 24;
   localparam logic [24:0] M_MEMEN    = 25'd1 << 23;
   localparam logic [24:0] M_PCEN     = 25'd1 << 22;
   localparam logic [24:0] M_ALUWE    = 25'd1 << 20;
   localparam logic [24:0] M_IRWE     = 25'd1 << 19;
   localparam logic [24:0] M_PCWE     = 25'd1 << 18;
   localparam logic [24:0] M_PCSEL1   = 25'd1 << 17;
   localparam logic [24:0] M_PCSEL0   = 25'd1 << 16;
   localparam logic [24:0] M_LRWE     = 25'd1 << 15;
   localparam logic [24:0] M_REGWE    = 25'd1 << 13;
   localparam logic [24:0] M_WDSEL    = 25'd1 << 12;
   localparam logic [24:0] M_RS1SEL0  = 25'd1 << 8;
   localparam logic [24:0] M_OP1SEL   = 25'd1 << 7;
   localparam logic [24:0] M_OP2SEL   = 25'd1 << 6;
   localparam logic [24:0] M_IMMSEL   = 25'd1 << 5;
   localparam logic [24:0] M_CFLAG    = 25'd1 << 4;
   localparam logic [24:0] M_MEMALE   = 25'd1 << 3;
   localparam logic [24:0] M_MEMREAD  = 25'd1 << 2;
   localparam logic [24:0] M_MEMWRITE = 25'd1 << 1;
   localparam logic [24:0] M_HALTED   = 25'd1;

   localparam logic [24:0] FET  = M_PCEN | M_MEMALE | M_PCWE;
   localparam logic [24:0] LDW8 = M_MEMEN | M_MEMREAD;
   localparam logic [24:0] LDI  = LDW8 | M_IRWE;
   localparam logic [24:0] ALU  = M_ALUEN | M_ALUWE | M_REGWE;
   localparam logic [24:0] TK   = M_ALUEN | M_OP1SEL | M_OP2SEL |
                                  M_IMMSEL | M_PCSEL0 | M_PCWE;
   localparam logic [24:0] MEMA = M_ALUEN | M_OP2SEL | M_MEMALE;
   localparam logic [24:0] LDM  = M_MEMEN | M_MEMREAD | M_WDSEL;
   localparam logic [24:0] STM  = M_RS1SEL0 | M_ALUEN | M_MEMWRITE;
   localparam logic [24:0] NONE = 25'd0;

   typedef struct {
      logic [15:0] ir;
      logic [3:0]  flags;
      logic [24:0] exec;
      logic [24:0] nxt;
   } vec_t;

   vec_t vecs[26];

   task automatic chk(input string name, input logic [24:0] exp);
      #1;
      total++;
      if (outv === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %07h expected %07h", name, outv, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   function automatic logic [24:0] cm();
      return Flags[1] ? M_CFLAG : NONE;
   endfunction

   task automatic do_reset();
      nReset = 1'b0;
      chk("reset_outputs", cm());
      step();
      nReset = 1'b1;
   endtask

   always @(negedge Clock) begin
      if (started) begin
         total++;
         if ($countones({AluEn, MemEn, PcEn, LrEn}) > 1) begin
            $display("FAIL bus_excl: got %b expected at most one set",
                     {AluEn, MemEn, PcEn, LrEn});
         end else begin
            passed++;
         end
      end
   end

   initial begin
      nReset   = 1'b0;
      Ir       = 16'h0000;
      Flags    = 4'h0;
      MemReady = 1'b1;

      vecs[0]  = '{16'h0123, 4'h0, ALU, FET};
      vecs[1]  = '{16'h0923, 4'h2, ALU | M_OP2SEL, FET};
      vecs[2]  = '{16'h7810, 4'h0, ALU | M_OP2SEL, FET};
      vecs[3]  = '{16'h3400, 4'h0, ALU, FET};
      vecs[4]  = '{16'hA105, 4'h8, TK, FET};
      vecs[5]  = '{16'hA105, 4'h0, NONE, FET};
      vecs[6]  = '{16'hA0FF, 4'h0, TK, FET};
      vecs[7]  = '{16'hA200, 4'h8, NONE, FET};
      vecs[8]  = '{16'hA300, 4'h2, TK, FET};
      vecs[9]  = '{16'hA400, 4'h2, NONE, FET};
      vecs[10] = '{16'hA500, 4'h4, TK, FET};
      vecs[11] = '{16'hA600, 4'h4, NONE, FET};
      vecs[12] = '{16'hA700, 4'h1, TK, FET};
      vecs[13] = '{16'hA800, 4'h0, TK, FET};
      vecs[14] = '{16'hA900, 4'h4, TK, FET};
      vecs[15] = '{16'hAA00, 4'h5, TK, FET};
      vecs[16] = '{16'hAA00, 4'h1, NONE, FET};
      vecs[17] = '{16'hAB00, 4'h0, NONE, FET};
      vecs[18] = '{16'hAF00, 4'hF, NONE, FET};
      vecs[19] = '{16'hB010, 4'h0, TK | M_LRWE, FET};
      vecs[20] = '{16'hC000, 4'h0, M_PCSEL1 | M_PCWE, FET};
      vecs[21] = '{16'hD000, 4'h0, NONE, FET};
      vecs[22] = '{16'hE000, 4'h0, NONE, FET};
      vecs[23] = '{16'h8000, 4'h0, MEMA, LDM | M_REGWE};
      vecs[24] = '{16'h9000, 4'h0, MEMA, STM};
      vecs[25] = '{16'hF000, 4'h0, NONE, M_HALTED};

      step();
      started = 1'b1;

      for (int i = 0; i < 26; i++) begin
         Ir       = vecs[i].ir;
         Flags    = vecs[i].flags;
         MemReady = 1'b1;
         do_reset();
         chk($sformatf("v%0d_fetch", i), FET | cm());
         step();
         chk($sformatf("v%0d_loadir", i), LDI | cm());
         step();
         chk($sformatf("v%0d_exec", i), vecs[i].exec | cm());
         step();
         chk($sformatf("v%0d_next", i), vecs[i].nxt | cm());
      end

      // LDW with two MEM wait states
      Ir = 16'h8000; Flags = 4'h0; MemReady = 1'b1;
      do_reset();
      chk("ldw_c1_fetch", FET);
      step();
      chk("ldw_c2_loadir", LDI);
      step();
      MemReady = 1'b0;
      chk("ldw_c3_exec", MEMA);
      step();
      chk("ldw_c4_mem_wait", LDM);
      step();
      chk("ldw_c5_mem_wait", LDM);
      step();
      MemReady = 1'b1;
      chk("ldw_c6_mem_done", LDM | M_REGWE);
      step();
      chk("ldw_c7_fetch", FET);

      // HALT holds for ten cycles; only reset leaves it
      Ir = 16'hF000; Flags = 4'h0; MemReady = 1'b1;
      do_reset();
      step();
      step();
      step();
      for (int k = 0; k < 10; k++) begin
         MemReady = k[0];
         chk($sformatf("halt_hold%0d", k), M_HALTED);
         step();
      end
      nReset = 1'b0;
      chk("halt_reset_low", NONE);
      step();
      nReset = 1'b1;
      chk("halt_release_fetch", FET);

      // STW with LOADIR wait, then reset during MEM wait
      Ir = 16'h9000; Flags = 4'h0; MemReady = 1'b0;
      do_reset();
      chk("stw_fetch", FET);
      step();
      chk("stw_loadir_wait", LDW8);
      step();
      MemReady = 1'b1;
      chk("stw_loadir_done", LDI);
      step();
      MemReady = 1'b0;
      chk("stw_exec", MEMA);
      step();
      chk("stw_mem_wait1", STM);
      step();
      chk("stw_mem_wait2", STM);
      nReset = 1'b0;
      chk("stw_reset_drop", NONE);
      step();
      nReset = 1'b1;
      chk("stw_after_fetch", FET);
      step();
      chk("stw_after_loadir", LDW8);

      step();
      started = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
